vram_arbiter: RTL and testbench

// Shares one single-port synchronous video RAM between the display fetch path and the CPU bus.
// The display fetch path is fed by the VGA timing counters and cannot be stalled, so it always wins a slot.
// The CPU gets every free cycle through a req/ack handshake.

---
 rtl/elc3_vram_pkg.sv | 16 +
 rtl/vram_arbiter_if.sv | 41 ++++
 rtl/vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vram_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/elc3_vram_pkg.sv
// Shared types and default geometry for the VRAM arbiter.
// Owner tags travel down the return pipe; the CPU FSM tracks its single outstanding access.
package elc3_vram_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 16;
  localparam int WAIT_W_DEF = 16;

  // Grant-to-return depth: one issue register plus one RAM read cycle.
  localparam int TAG_STAGES = 2;

  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU} vram_owner_t;

  typedef enum {C_IDLE, C_ISSUE, C_RESP} cpu_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of display, CPU and VRAM-macro signals around the arbiter.
// slave = arbiter side, master = surrounding fetch logic / CPU / RAM.
interface vram_arbiter_if
  import elc3_vram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WAIT_W = WAIT_W_DEF
) ();

  logic              Disp_Req;
  logic [ADDR_W-1:0] Disp_Addr;
  logic              Disp_Valid;
  logic [DATA_W-1:0] Disp_Data;

  logic              Cpu_Req;
  logic              Cpu_WE;
  logic [ADDR_W-1:0] Cpu_Addr;
  logic [DATA_W-1:0] Cpu_WData;
  logic              Cpu_Ack;
  logic [DATA_W-1:0] Cpu_RData;
  logic [WAIT_W-1:0] Cpu_Wait;

  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_WE;
  logic [DATA_W-1:0] Mem_WData;
  logic [DATA_W-1:0] Mem_RData;

  modport slave (
    input  Disp_Req, Disp_Addr, Cpu_Req, Cpu_WE, Cpu_Addr, Cpu_WData, Mem_RData,
    output Disp_Valid, Disp_Data, Cpu_Ack, Cpu_RData, Cpu_Wait,
           Mem_Addr, Mem_WE, Mem_WData
  );

  modport master (
    output Disp_Req, Disp_Addr, Cpu_Req, Cpu_WE, Cpu_Addr, Cpu_WData, Mem_RData,
    input  Disp_Valid, Disp_Data, Cpu_Ack, Cpu_RData, Cpu_Wait,
           Mem_Addr, Mem_WE, Mem_WData
  );

endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch always wins, CPU takes free cycles.
// Both requesters see a fixed 2-cycle grant-to-return latency via an owner-tag pipe.
module vram_arbiter
  import elc3_vram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WAIT_W = WAIT_W_DEF
) (
  input  logic          Clk,
  input  logic          Reset_N,
  vram_arbiter_if.slave bus
);

  cpu_state_t          r_state, w_state_nxt;
  vram_owner_t         w_grant;
  vram_owner_t         r_tag [1:TAG_STAGES];
  logic [TAG_STAGES:1] r_cpu_rd;

  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_disp_data;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [WAIT_W-1:0]   r_wait;

  logic                w_disp_vld;
  logic                w_cpu_ack;
  logic                w_cpu_rd_ret;
  logic                w_wait_inc;

  // Display has absolute priority; CPU only when no access of its own is in flight.
  always_comb begin
    w_grant = OWN_NONE;
    if (bus.Disp_Req)
      w_grant = OWN_DISP;
    else if (r_state == C_IDLE && bus.Cpu_Req)
      w_grant = OWN_CPU;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE:  if (w_grant == OWN_CPU) w_state_nxt = C_ISSUE;
      C_ISSUE: w_state_nxt = C_RESP;
      C_RESP:  w_state_nxt = C_IDLE;
      default: w_state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) r_state <= C_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Issue stage: RAM address/control are registered straight from the winner.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      case (w_grant)
        OWN_DISP: begin
          r_mem_addr <= bus.Disp_Addr;
          r_mem_we   <= 1'b0;
        end
        OWN_CPU: begin
          r_mem_addr  <= bus.Cpu_Addr;
          r_mem_we    <= bus.Cpu_WE;
          r_mem_wdata <= bus.Cpu_WData;
        end
        default: r_mem_we <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int i = 1; i <= TAG_STAGES; i++) r_tag[i] <= OWN_NONE;
      r_cpu_rd <= '0;
    end else begin
      r_tag[1]    <= w_grant;
      r_cpu_rd[1] <= (w_grant == OWN_CPU) && !bus.Cpu_WE;
      for (int i = 2; i <= TAG_STAGES; i++) begin
        r_tag[i]    <= r_tag[i-1];
        r_cpu_rd[i] <= r_cpu_rd[i-1];
      end
    end
  end

  assign w_disp_vld   = (r_tag[TAG_STAGES] == OWN_DISP);
  assign w_cpu_ack    = (r_tag[TAG_STAGES] == OWN_CPU);
  assign w_cpu_rd_ret = w_cpu_ack && r_cpu_rd[TAG_STAGES];

  // RAM data is only valid in the return cycle, so keep a copy for the hold behaviour.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_disp_data <= '0;
      r_cpu_rdata <= '0;
    end else begin
      if (w_disp_vld)   r_disp_data <= bus.Mem_RData;
      if (w_cpu_rd_ret) r_cpu_rdata <= bus.Mem_RData;
    end
  end

  assign w_wait_inc = bus.Cpu_Req && (r_state == C_IDLE) && (w_grant != OWN_CPU);

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N)                         r_wait <= '0;
    else if (w_wait_inc && r_wait != '1)  r_wait <= r_wait + 1'b1;
  end

  assign bus.Disp_Valid = w_disp_vld;
  assign bus.Disp_Data  = w_disp_vld ? bus.Mem_RData : r_disp_data;
  assign bus.Cpu_Ack    = w_cpu_ack;
  assign bus.Cpu_RData  = w_cpu_rd_ret ? bus.Mem_RData : r_cpu_rdata;
  assign bus.Cpu_Wait   = r_wait;
  assign bus.Mem_Addr   = r_mem_addr;
  assign bus.Mem_WE     = r_mem_we;
  assign bus.Mem_WData  = r_mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: stimulus pushes expected returns, a monitor pops them.
module tb_vram_arbiter;
  import elc3_vram_pkg::*;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam int WW = 4;

  logic Clk = 1'b0;
  logic Reset_N = 1'b0;
  always #10 Clk = ~Clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .WAIT_W(WW)) bus ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_W(WW)) dut (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .bus     (bus)
  );

  logic [DW-1:0] vram [0:(1<<AW)-1];

  always @(posedge Clk) begin
    if (bus.Mem_WE) vram[bus.Mem_Addr] <= bus.Mem_WData;
    bus.Mem_RData <= vram[bus.Mem_Addr];
  end

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t disp_q[$];
  exp_t cpu_q[$];
  exp_t me, mc;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (Reset_N) begin
      if (bus.Disp_Valid) begin
        if (disp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL disp_unexpected: Disp_Valid with data %0h, expected none (cycle %0d)", bus.Disp_Data, cyc);
        end else begin
          me = disp_q.pop_front();
          check("disp_data", 32'(bus.Disp_Data), 32'(me.data));
          check("disp_cycle", cyc, me.cyc);
        end
      end
      if (bus.Cpu_Ack) begin
        if (cpu_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL cpu_unexpected: Cpu_Ack with rdata %0h, expected none (cycle %0d)", bus.Cpu_RData, cyc);
        end else begin
          mc = cpu_q.pop_front();
          check("cpu_rdata", 32'(bus.Cpu_RData), 32'(mc.data));
          check("cpu_cycle", cyc, mc.cyc);
        end
      end
    end
  end

  task automatic disp_strobe(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 2;
    disp_q.push_back(e);
    bus.Disp_Req  = 1'b1;
    bus.Disp_Addr = a;
    tick();
    bus.Disp_Req  = 1'b0;
  endtask

  // Holds Cpu_Req until Ack, then one idle cycle so the FSM is back in C_IDLE.
  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic [DW-1:0] exp_rd, input int lat, input bit chk_issue);
    exp_t e;
    int   n;
    e.data = exp_rd;
    e.cyc  = cyc + lat;
    cpu_q.push_back(e);
    bus.Cpu_Req   = 1'b1;
    bus.Cpu_WE    = we;
    bus.Cpu_Addr  = a;
    bus.Cpu_WData = wd;
    tick();
    if (chk_issue) begin
      check("issue_addr", 32'(bus.Mem_Addr), 32'(a));
      check("issue_we", 32'(bus.Mem_WE), 32'(we));
    end
    n = 0;
    while (!bus.Cpu_Ack && n < 40) begin
      tick();
      n++;
    end
    if (!bus.Cpu_Ack) begin
      n_tests++; n_fail++;
      $display("FAIL cpu_ack_timeout: no Cpu_Ack within 40 cycles for addr %0h", a);
    end
    bus.Cpu_Req = 1'b0;
    bus.Cpu_WE  = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_disp_valid"}, 32'(bus.Disp_Valid), 0);
    check({tag, "_disp_data"},  32'(bus.Disp_Data),  0);
    check({tag, "_cpu_ack"},    32'(bus.Cpu_Ack),    0);
    check({tag, "_cpu_rdata"},  32'(bus.Cpu_RData),  0);
    check({tag, "_cpu_wait"},   32'(bus.Cpu_Wait),   0);
    check({tag, "_mem_addr"},   32'(bus.Mem_Addr),   0);
    check({tag, "_mem_we"},     32'(bus.Mem_WE),     0);
    check({tag, "_mem_wdata"},  32'(bus.Mem_WData),  0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) vram[i] = '0;
    for (int i = 0; i < 8; i++)  vram[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 20; i++) vram[16'h40 + i] = 16'h4000 + 16'(i);
    vram[16'h10] = 16'hBEEF;
    vram[16'h21] = 16'hAAAA;

    bus.Disp_Req  = 1'b0;
    bus.Disp_Addr = '0;
    bus.Cpu_Req   = 1'b0;
    bus.Cpu_WE    = 1'b0;
    bus.Cpu_Addr  = '0;
    bus.Cpu_WData = '0;

    repeat (3) tick();
    check_all_zero("reset");
    Reset_N = 1'b1;
    repeat (2) tick();

    // 1: lone CPU read
    cpu_access(1'b0, 13'h0010, '0, 16'hBEEF, 2, 1'b1);
    check("t1_wait", 32'(bus.Cpu_Wait), 0);

    // 2: display every second cycle, addresses 0..3
    for (int i = 0; i < 4; i++) begin
      disp_strobe(AW'(i), 16'h1000 + 16'(i));
      tick();
    end
    repeat (2) tick();

    // 3: simultaneous display and CPU write; CPU slips one cycle
    fork
      disp_strobe(13'h0001, 16'h1001);
      cpu_access(1'b1, 13'h0005, 16'h1234, 16'hBEEF, 3, 1'b0);
    join
    check("t3_wait", 32'(bus.Cpu_Wait), 1);
    cpu_access(1'b0, 13'h0005, '0, 16'h1234, 2, 1'b1);

    // 4a: CPU write then display read of same address sees new data
    fork
      cpu_access(1'b1, 13'h0020, 16'h5555, 16'h1234, 2, 1'b1);
      begin tick(); disp_strobe(13'h0020, 16'h5555); end
    join
    // 4b: display read then CPU write sees old data
    fork
      disp_strobe(13'h0021, 16'hAAAA);
      begin tick(); cpu_access(1'b1, 13'h0021, 16'h7777, 16'h1234, 2, 1'b0); end
    join
    cpu_access(1'b0, 13'h0021, '0, 16'h7777, 2, 1'b0);
    check("t4_wait", 32'(bus.Cpu_Wait), 1);

    // 6: reset while a CPU read sits in C_ISSUE
    bus.Cpu_Req  = 1'b1;
    bus.Cpu_WE   = 1'b0;
    bus.Cpu_Addr = 13'h0010;
    tick();
    check("t6_issue_addr", 32'(bus.Mem_Addr), 32'h10);
    Reset_N = 1'b0;
    #1;
    check_all_zero("midrst");
    bus.Cpu_Req = 1'b0;
    repeat (3) tick();
    Reset_N = 1'b1;
    repeat (4) tick();
    cpu_access(1'b0, 13'h0010, '0, 16'hBEEF, 2, 1'b1);
    check("t6_wait", 32'(bus.Cpu_Wait), 0);

    // 5: continuous display traffic starves the CPU; counter saturates
    fork
      for (int i = 0; i < 20; i++) begin
        if (i == 10) check("t5_wait_mid", 32'(bus.Cpu_Wait), 10);
        if (i == 16) check("t5_wait_sat", 32'(bus.Cpu_Wait), 15);
        disp_strobe(AW'(16'h40 + i), 16'h4000 + 16'(i));
      end
      cpu_access(1'b0, 13'h0010, '0, 16'hBEEF, 22, 1'b0);
    join
    check("t5_wait_end", 32'(bus.Cpu_Wait), 15);

    repeat (5) tick();
    check("disp_q_drained", disp_q.size(), 0);
    check("cpu_q_drained", cpu_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
